// File: rtl/crc_frame_tx.sv
// Framing transmitter: accepts a payload, computes its CRC one bit per clock (MSB first),
// then holds {data, crc, parity} on the output until the downstream handshake.
module crc_frame_tx #(
  parameter int unsigned DATA_W    = 11,
  parameter int unsigned CRC_W     = 4,
  parameter logic [CRC_W-1:0] POLY = 4'b0011,
  parameter logic [CRC_W-1:0] INIT = 4'b0000,
  parameter int unsigned PARITY_EN = 1,
  parameter int unsigned CNT_W     = 8,
  localparam int unsigned FRAME_W  = DATA_W + CRC_W + PARITY_EN
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [FRAME_W-1:0] frame_out,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic [CNT_W-1:0]   frame_cnt
);

  localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               state_q;
  logic [DATA_W-1:0]    shift_q, shift_d;
  logic [CRC_W-1:0]     crc_q, crc_d;
  logic [BIT_W-1:0]     bit_q;
  logic [FRAME_W-1:0]   frame_q, frame_d;
  logic                 out_valid_q;
  logic [CNT_W-1:0]     cnt_q;

  // The shift register rotates rather than shifts, so after DATA_W steps it holds
  // the original payload again and no separate data copy is needed.
  always_comb begin
    crc_d   = {crc_q[CRC_W-2:0], 1'b0} ^ ((crc_q[CRC_W-1] ^ shift_q[DATA_W-1]) ? POLY : '0);
    shift_d = (shift_q << 1) | (shift_q >> (DATA_W - 1));
  end

  generate
    if (PARITY_EN != 0) begin : g_par
      always_comb frame_d = {shift_d, crc_d, ^{shift_d, crc_d}};
    end else begin : g_nopar
      always_comb frame_d = {shift_d, crc_d};
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      crc_q       <= '0;
      bit_q       <= '0;
      frame_q     <= '0;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            shift_q <= in_data;
            crc_q   <= INIT;
            bit_q   <= '0;
            state_q <= CALC;
          end
        end
        CALC: begin
          shift_q <= shift_d;
          crc_q   <= crc_d;
          bit_q   <= bit_q + BIT_W'(1);
          if (bit_q == BIT_LAST) begin
            frame_q     <= frame_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            cnt_q       <= cnt_q + CNT_W'(1);
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = !in_ready;
  assign frame_out = frame_q;
  assign out_valid = out_valid_q;
  assign frame_cnt = cnt_q;

endmodule

// File: tb/tb_crc_frame_tx.sv
// Directed bench for crc_frame_tx: default 11/4 configuration plus an 8/8 no-parity instance.
module tb_crc_frame_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] in_data;
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [15:0] frame_out;
  logic [7:0]  frame_cnt;

  logic [7:0]  in_data8;
  logic        in_valid8, in_ready8, out_valid8, out_ready8, busy8;
  logic [15:0] frame_out8;
  logic [7:0]  frame_cnt8;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  crc_frame_tx dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .frame_out(frame_out), .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
    .frame_cnt(frame_cnt)
  );

  crc_frame_tx #(
    .DATA_W(8), .CRC_W(8), .POLY(8'h07), .INIT(8'h00), .PARITY_EN(0), .CNT_W(8)
  ) dut8 (
    .clk(clk), .reset(reset), .in_data(in_data8), .in_valid(in_valid8), .in_ready(in_ready8),
    .frame_out(frame_out8), .out_valid(out_valid8), .out_ready(out_ready8), .busy(busy8),
    .frame_cnt(frame_cnt8)
  );

  // Hand-derived frames for the 11-bit / x^4+x+1 configuration.
  logic [10:0] vd [4] = '{11'h001, 11'h002, 11'h400, 11'h003};
  logic [15:0] vf [4] = '{16'h0027, 16'h004D, 16'h8013, 16'h006A};

  task automatic run_frame(input logic [10:0] d, input logic [15:0] exp, input string nm);
    int lat;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL %s_in_ready: got %b want 1", nm, in_ready); end
    in_data = d; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_data = ~d;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
    checks++;
    if (lat !== 11) begin errors++; $display("FAIL %s_latency: got %0d want 11", nm, lat); end
    checks++;
    if (frame_out !== exp) begin errors++; $display("FAIL %s_frame: got %h want %h", nm, frame_out, exp); end
    @(negedge clk);
    exp_cnt++;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL %s_valid_clear: got %b want 0", nm, out_valid); end
    checks++;
    if (frame_cnt !== 8'(exp_cnt)) begin errors++; $display("FAIL %s_cnt: got %0d want %0d", nm, frame_cnt, 8'(exp_cnt)); end
  endtask

  task automatic test_reset();
    reset = 1'b1; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
    in_data8 = '0; in_valid8 = 1'b0; out_ready8 = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({in_ready, busy, out_valid} !== 3'b100) begin errors++; $display("FAIL reset_ctrl: got %b want 100", {in_ready, busy, out_valid}); end
    checks++;
    if (frame_out !== 16'h0000) begin errors++; $display("FAIL reset_frame: got %h want 0000", frame_out); end
    checks++;
    if (frame_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", frame_cnt); end
    checks++;
    if ({in_ready8, busy8, out_valid8} !== 3'b100) begin errors++; $display("FAIL reset_ctrl8: got %b want 100", {in_ready8, busy8, out_valid8}); end
    reset = 1'b0;
    exp_cnt = 0;
  endtask

  task automatic test_reset_mid_calc();
    int bad;
    @(negedge clk);
    in_data = 11'h001; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL midcalc_busy: got %b want 1", busy); end
    reset = 1'b1;
    #1;
    checks++;
    if ({in_ready, busy, out_valid} !== 3'b100) begin errors++; $display("FAIL midcalc_async: got %b want 100", {in_ready, busy, out_valid}); end
    @(negedge clk);
    reset = 1'b0;
    bad = 0;
    repeat (15) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || frame_cnt !== 8'd0 || in_ready !== 1'b1) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL midcalc_discard: %0d bad cycles want 0", bad); end
    exp_cnt = 0;
    run_frame(11'h003, 16'h006A, "after_reset");
  endtask

  task automatic test_single();
    run_frame(11'h001, 16'h0027, "single_001");
  endtask

  task automatic test_vectors();
    run_frame(11'h002, 16'h004D, "vec_002");
    run_frame(11'h400, 16'h8013, "vec_400");
    run_frame(11'h003, 16'h006A, "vec_003");
  endtask

  task automatic test_stall();
    int g, bad;
    @(negedge clk);
    in_data = 11'h000; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    g = 0;
    while (out_valid !== 1'b1 && g < 40) begin @(negedge clk); g++; end
    checks++;
    if (g !== 11) begin errors++; $display("FAIL stall_latency: got %0d want 11", g); end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      in_valid = (i % 2 == 0); in_data = 11'h3FF;
      @(negedge clk);
      if (out_valid !== 1'b1 || frame_out !== 16'h0000 || in_ready !== 1'b0 || busy !== 1'b1) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL stall_hold: %0d bad cycles want 0", bad); end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    exp_cnt++;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL stall_release: got %b want 01", {out_valid, in_ready}); end
    checks++;
    if (frame_cnt !== 8'(exp_cnt)) begin errors++; $display("FAIL stall_cnt: got %0d want %0d", frame_cnt, 8'(exp_cnt)); end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_no_accept: got %b want 1", in_ready); end
  endtask

  task automatic test_param();
    logic [7:0]  pd [2] = '{8'h01, 8'h00};
    logic [15:0] pf [2] = '{16'h0107, 16'h0000};
    int g;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      in_data8 = pd[k]; in_valid8 = 1'b1; out_ready8 = 1'b1;
      @(negedge clk);
      in_valid8 = 1'b0; in_data8 = 8'hA5;
      g = 0;
      while (out_valid8 !== 1'b1 && g < 40) begin @(negedge clk); g++; end
      checks++;
      if (g !== 8) begin errors++; $display("FAIL param_latency%0d: got %0d want 8", k, g); end
      checks++;
      if (frame_out8 !== pf[k]) begin errors++; $display("FAIL param_frame%0d: got %h want %h", k, frame_out8, pf[k]); end
      @(negedge clk);
      checks++;
      if (frame_cnt8 !== 8'(k + 1)) begin errors++; $display("FAIL param_cnt%0d: got %0d want %0d", k, frame_cnt8, k + 1); end
    end
  endtask

  task automatic test_back_to_back();
    int t, last, g;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    in_data = vd[0]; in_valid = 1'b1; out_ready = 1'b1;
    t = 0; last = 0;
    for (int f = 1; f <= 257; f++) begin
      g = 0;
      while (in_ready !== 1'b1 && g < 40) begin @(negedge clk); t++; g++; end
      if (f > 1) begin
        checks++;
        if (t - last !== 13) begin errors++; $display("FAIL b2b_spacing%0d: got %0d want 13", f, t - last); end
      end
      last = t;
      @(negedge clk); t++;
      in_data = vd[f % 4];
      g = 0;
      while (out_valid !== 1'b1 && g < 40) begin @(negedge clk); t++; g++; end
      checks++;
      if (frame_out !== vf[(f - 1) % 4]) begin errors++; $display("FAIL b2b_frame%0d: got %h want %h", f, frame_out, vf[(f - 1) % 4]); end
      @(negedge clk); t++;
      checks++;
      if (frame_cnt !== 8'(f)) begin errors++; $display("FAIL b2b_cnt%0d: got %0d want %0d", f, frame_cnt, 8'(f)); end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_reset_mid_calc();
    test_single();
    test_vectors();
    test_stall();
    test_param();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
